// File: rtl/slow_tick_rx.sv
// Receiver for the divider's slow square wave: synchronizes and glitch-filters it,
// emits one-cycle tick enables in the clk domain, and tracks tick count, period and loss.
module slow_tick_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int CNT_W       = 8,
   parameter int PER_W       = 16,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             slow_in,
   input  logic             en,
   input  logic             clr_to,
   output logic             tick,
   output logic [CNT_W-1:0] tick_count,
   output logic [PER_W-1:0] period,
   output logic             period_valid,
   output logic             timeout
);

   localparam int               FC_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(FILTER_LEN - 1);
   localparam logic [PER_W-1:0] TO_CYC  = PER_W'(TIMEOUT_CYC);
   localparam logic [PER_W-1:0] CYC_MAX = '1;

   typedef enum logic [1:0] {IDLE, WAIT_FIRST, RUN, LOST} state_t;

   state_t             state, state_nx;
   logic [SYNC_STAGES-1:0] sync_q;
   logic               s, f;
   logic [FC_W-1:0]    fcnt;
   logic               rise_d, tick_d;
   logic [PER_W-1:0]   cyc, cyc_nx;
   logic [CNT_W-1:0]   cnt_nx;
   logic [PER_W-1:0]   per_nx;
   logic               pv_nx, to_nx;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // A level change is accepted only after s disagrees with f for FILTER_LEN samples
   always_ff @(posedge clk) begin
      if (rst) begin
         f    <= 1'b0;
         fcnt <= '0;
      end else if (s == f) begin
         fcnt <= '0;
      end else if (fcnt == FC_MAX) begin
         f    <= s;
         fcnt <= '0;
      end else begin
         fcnt <= fcnt + 1'b1;
      end
   end

   assign rise_d = s & ~f & (fcnt == FC_MAX);
   assign tick_d = rise_d & en & (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         tick         <= 1'b0;
         cyc          <= '0;
         tick_count   <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_nx;
         tick         <= tick_d;
         cyc          <= cyc_nx;
         tick_count   <= cnt_nx;
         period       <= per_nx;
         period_valid <= pv_nx;
         timeout      <= to_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cyc_nx   = cyc;
      cnt_nx   = tick_count;
      per_nx   = period;
      pv_nx    = period_valid;
      to_nx    = timeout & ~clr_to;
      if (!en) begin
         state_nx = IDLE;
         cyc_nx   = '0;
         pv_nx    = 1'b0;
         to_nx    = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_nx = WAIT_FIRST;
               cyc_nx   = '0;
            end
            WAIT_FIRST: begin
               if (tick_d) begin
                  state_nx = RUN;
                  cyc_nx   = PER_W'(1);
                  cnt_nx   = tick_count + 1'b1;
               end else if (cyc >= TO_CYC) begin
                  state_nx = LOST;
                  to_nx    = 1'b1;
               end else begin
                  cyc_nx = cyc + 1'b1;
               end
            end
            RUN: begin
               // A tick landing on the timeout cycle still counts as a measurement
               if (tick_d) begin
                  per_nx = cyc;
                  pv_nx  = 1'b1;
                  cyc_nx = PER_W'(1);
                  cnt_nx = tick_count + 1'b1;
               end else if (cyc >= TO_CYC) begin
                  state_nx = LOST;
                  pv_nx    = 1'b0;
                  to_nx    = 1'b1;
               end else if (cyc != CYC_MAX) begin
                  cyc_nx = cyc + 1'b1;
               end
            end
            LOST: begin
               if (tick_d) begin
                  state_nx = RUN;
                  cyc_nx   = PER_W'(1);
                  cnt_nx   = tick_count + 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_slow_tick_rx.sv
// Directed bench for slow_tick_rx: a phase table for the steady-state wave and glitches,
// plus hand sequences for latency, timeout boundaries, wrap, enable and reset.
module tb_slow_tick_rx;

   logic        clk = 1'b0;
   logic        rst, slow_in, en, clr_to;
   logic        tick;
   logic [7:0]  tick_count;
   logic [15:0] period;
   logic        period_valid, timeout;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   slow_tick_rx dut (
      .clk          (clk),
      .rst          (rst),
      .slow_in      (slow_in),
      .en           (en),
      .clr_to       (clr_to),
      .tick         (tick),
      .tick_count   (tick_count),
      .period       (period),
      .period_valid (period_valid),
      .timeout      (timeout)
   );

   typedef struct {
      logic slow;
      logic en;
      logic clr;
      int   cyc;
      int   ticks;
      int   cnt;
      int   per;
      logic pv;
      logic to;
   } vec_t;

   vec_t vt [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 time unit after each; counts tick pulses seen.
   task automatic run(input int n, output int nt);
      nt = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (tick === 1'b1) nt++;
      end
   endtask

   task automatic outs(input string tag, input int cnt, input int per, input logic pv, input logic to);
      chk({tag, "_cnt"}, 32'(tick_count), cnt);
      chk({tag, "_per"}, 32'(period), per);
      chk({tag, "_pv"},  32'(period_valid), 32'(pv));
      chk({tag, "_to"},  32'(timeout), 32'(to));
   endtask

   initial begin
      int nt, tot;

      vt[0]  = '{1'b1, 1'b1, 1'b0, 12, 0, 1,  0, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 1'b0, 20, 0, 1,  0, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 1'b0, 20, 1, 2, 40, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 20, 0, 2, 40, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 1'b0, 20, 1, 3, 40, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 20, 0, 3, 40, 1'b1, 1'b0};
      vt[6]  = '{1'b1, 1'b1, 1'b0, 20, 1, 4, 40, 1'b1, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 20, 0, 4, 40, 1'b1, 1'b0};
      vt[8]  = '{1'b1, 1'b1, 1'b0, 20, 1, 5, 40, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 20, 0, 5, 40, 1'b1, 1'b0};
      vt[10] = '{1'b1, 1'b1, 1'b0,  1, 0, 5, 40, 1'b1, 1'b0};
      vt[11] = '{1'b0, 1'b1, 1'b0, 10, 0, 5, 40, 1'b1, 1'b0};
      vt[12] = '{1'b1, 1'b1, 1'b0,  2, 0, 5, 40, 1'b1, 1'b0};
      vt[13] = '{1'b0, 1'b1, 1'b0, 10, 0, 5, 40, 1'b1, 1'b0};
      vt[14] = '{1'b1, 1'b1, 1'b0,  3, 0, 5, 40, 1'b1, 1'b0};
      vt[15] = '{1'b0, 1'b1, 1'b0, 10, 0, 5, 40, 1'b1, 1'b0};

      rst = 1'b1; en = 1'b0; slow_in = 1'b0; clr_to = 1'b0;
      run(3, nt);
      chk("rst_tick", 32'(tick), 0);
      outs("rst", 0, 0, 1'b0, 1'b0);

      // First rise: tick exactly on the 6th edge after slow_in goes high
      rst = 1'b0; en = 1'b1; slow_in = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         run(1, nt);
         chk($sformatf("lat_e%0d", k), 32'(tick), (k == 6) ? 1 : 0);
      end
      outs("first", 1, 0, 1'b0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         slow_in = vt[i].slow; en = vt[i].en; clr_to = vt[i].clr;
         run(vt[i].cyc, nt);
         chk($sformatf("v%0d_ticks", i), nt, vt[i].ticks);
         outs($sformatf("v%0d", i), vt[i].cnt, vt[i].per, vt[i].pv, vt[i].to);
      end
      clr_to = 1'b0;

      // Tick 76 cycles after the previous one
      slow_in = 1'b1;
      run(6, nt);
      chk("p76_tick", 32'(tick), 1);
      outs("p76", 6, 76, 1'b1, 1'b0);

      // Next tick lands exactly when the cycle count hits 1000: tick wins
      slow_in = 1'b0;
      run(994, nt);
      slow_in = 1'b1;
      run(5, nt);
      chk("edge_pre_to", 32'(timeout), 0);
      run(1, nt);
      chk("edge_tick", 32'(tick), 1);
      outs("edge", 7, 1000, 1'b1, 1'b0);

      // Stall: timeout appears on the 1000th cycle, not before
      run(999, nt);
      chk("stall999_to", 32'(timeout), 0);
      chk("stall999_ticks", nt, 0);
      run(1, nt);
      outs("lost", 7, 1000, 1'b0, 1'b1);

      slow_in = 1'b0; run(10, nt);
      slow_in = 1'b1; run(6, nt);
      chk("resume_tick", 32'(tick), 1);
      outs("resume", 8, 1000, 1'b0, 1'b1);

      clr_to = 1'b1; run(1, nt); clr_to = 1'b0;
      chk("clr_to", 32'(timeout), 0);

      slow_in = 1'b0; run(10, nt);
      slow_in = 1'b1; run(20, nt);
      chk("remeas_ticks", nt, 1);
      outs("remeas", 9, 17, 1'b1, 1'b0);

      // 247 more ticks brings the count to 256, wrapping to 0
      tot = 0;
      for (int i = 0; i < 247; i++) begin
         slow_in = 1'b0; run(6, nt); tot += nt;
         slow_in = 1'b1; run(6, nt); tot += nt;
      end
      chk("wrap_ticks", tot, 247);
      outs("wrap", 0, 12, 1'b1, 1'b0);

      // en drops on the very cycle the filtered rise lands
      slow_in = 1'b0; run(10, nt);
      slow_in = 1'b1; run(5, nt);
      en = 1'b0; run(1, nt);
      chk("enfall_tick", 32'(tick), 0);
      chk("enfall_pv", 32'(period_valid), 0);
      chk("enfall_to", 32'(timeout), 0);
      tot = 0;
      for (int i = 0; i < 3; i++) begin
         slow_in = 1'b0; run(6, nt); tot += nt;
         slow_in = 1'b1; run(6, nt); tot += nt;
      end
      chk("dis_ticks", tot, 0);
      chk("dis_cnt", 32'(tick_count), 0);

      // Re-enable while slow_in is already high: no tick until a real rise
      en = 1'b1; run(20, nt);
      chk("reen_ticks", nt, 0);
      slow_in = 1'b0; run(10, nt);
      slow_in = 1'b1; run(10, nt);
      chk("reen1_ticks", nt, 1);
      outs("reen1", 1, 12, 1'b0, 1'b0);
      slow_in = 1'b0; run(10, nt);
      slow_in = 1'b1; run(10, nt);
      chk("reen2_ticks", nt, 1);
      outs("reen2", 2, 20, 1'b1, 1'b0);

      rst = 1'b1; run(1, nt);
      chk("mid_rst_tick", 32'(tick), 0);
      outs("mid_rst", 0, 0, 1'b0, 1'b0);

      // slow_in already high at reset release counts as a rise
      rst = 1'b0; run(10, nt);
      chk("hi_rel_ticks", nt, 1);
      chk("hi_rel_cnt", 32'(tick_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/slow_tick_rx.md
Name: slow_tick_rx

Overview:
Receiving end of the divided slow clock produced by the stopwatch's ripple flip-flop divider chain. It takes the slow square wave, which is asynchronous to the main clock, and synchronizes and glitch-filters it. It converts each filtered rising edge into a single-cycle `tick` enable in the `clk` domain. It also counts ticks, measures the tick period in `clk` cycles, and flags a lost slow clock, so the stopwatch counters run off `clk` with an enable instead of a ripple clock.

Parameters:
SYNC_STAGES, 2, synchronizer flip-flops on slow_in (min 2)
FILTER_LEN, 4, consecutive stable synchronized samples required to accept a level change (min 1)
CNT_W, 8, width of tick_count
PER_W, 16, width of period and internal cycle counter
TIMEOUT_CYC, 1000, cycles without a tick before declaring loss (< 2^PER_W)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
slow_in  input  1  slow square wave from divider, asynchronous to clk
en  input  1  enable; 0 forces IDLE
clr_to  input  1  one-cycle pulse, clears sticky timeout
tick  output  1  one-cycle pulse per accepted rising edge of slow_in
tick_count  output  CNT_W  ticks since reset/enable, wraps
period  output  PER_W  clk cycles between the last two ticks
period_valid  output  1  period holds a real measurement
timeout  output  1  sticky: no tick for TIMEOUT_CYC cycles

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset values: sync chain 0, filtered level f=0, filter count 0, state IDLE, tick=0, tick_count=0, period=0, period_valid=0, timeout=0, cycle count 0.
- Synchronizer: SYNC_STAGES flops; its last stage is s. It runs regardless of en.
- Filter (runs regardless of en):
  - If s==f, the filter count is cleared.
  - If s!=f and count<FILTER_LEN-1, the count increments.
  - If s!=f and count==FILTER_LEN-1, f<=s and the count is cleared.
  - Pulses on s shorter than FILTER_LEN cycles never change f.
- Edge detect: an accepted rise is the cycle in which f goes 0->1. tick is registered and asserted in that same clock edge.
- Latency: tick is high for exactly one cycle, starting at clock edge SYNC_STAGES+FILTER_LEN, counting the first edge that samples slow_in=1 as edge 1. With defaults that is edge 6. Falling edges produce no tick.
- tick is gated by state: it is forced to 0 in IDLE.
- FSM states:
  - IDLE: entered on rst or en=0. Cycle count=0, period_valid=0, timeout=0, tick_count holds. On en=1 -> WAIT_FIRST with cycle count=0.
  - WAIT_FIRST: cycle count increments. On tick -> RUN, cycle count<=1, tick_count+1. If count reaches TIMEOUT_CYC without a tick -> LOST.
  - RUN: cycle count increments, saturating at 2^PER_W-1. On tick: period<=count, period_valid<=1, count<=1, tick_count+1. If count reaches TIMEOUT_CYC without a tick -> LOST, period_valid<=0.
  - LOST: timeout=1. Cycle count holds. On tick -> RUN, count<=1, tick_count+1. period_valid stays 0 until the next tick measures a fresh period.
- period semantics: ticks at cycles t0 and t1 give period = t1-t0. period holds its value between ticks and holds when entering LOST.
- timeout:
  - Set on entry to LOST.
  - Cleared by rst, by en=0, or by clr_to.
  - It stays set through LOST->RUN until cleared.
- tick_count: increments by 1 per tick, mod 2^CNT_W (255 -> 0 with defaults). It is cleared on rst only; en toggling holds it.
- Simultaneous events:
  - A tick in the same cycle the count reaches TIMEOUT_CYC: the tick wins, no timeout.
  - clr_to in the same cycle timeout is being set: set wins.
  - en falling in the same cycle as a filtered rise: no tick, go to IDLE.
- slow_in already high at reset release: f rises after the filter latency. This is treated as an accepted rise, so a tick is emitted if en=1.
- en rising while slow_in is high: no tick until the next real rise, because f already matches s.

Test Plan:
- rst, en=1, slow_in 0->1 held high -> tick high for exactly one cycle at edge 6 after the first sampling edge; tick_count=1; state RUN; period_valid=0.
- slow_in square wave with 40-cycle period, 5 rises -> tick every 40 cycles; after the 2nd tick period=40, period_valid=1; tick_count=5.
- Glitches on slow_in of 1, 2 and 3 cycles high (defaults) -> no tick, f unchanged, tick_count unchanged.
- slow_in stopped for 1000 cycles after a tick -> timeout=1 and period_valid=0 at count 1000. Resume -> tick, timeout still 1. clr_to pulse -> timeout=0. A 2nd tick restores period_valid=1.
- 256 ticks with CNT_W=8 -> tick_count wraps to 0. Drop en mid-stream -> no ticks, tick_count holds, timeout=0. Re-raise en -> WAIT_FIRST, next rise resumes the count.
- Tick arriving exactly when count==TIMEOUT_CYC -> no timeout, period=1000. Assert rst mid-RUN -> all outputs 0 on the next edge.
